// File: rtl/onchip_mem_byte_loader.sv
// Byte-stream loader for the 1024x32 on-chip RAM.
// Packs bytes little-endian into words and writes them from base_addr.
// Ports: clk, reset (sync, high), start, base_addr, in_* (byte stream),
// RAM write port (address..clken), busy, done, word_count, wrapped.
module onchip_mem_byte_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              wrapped
);

  typedef enum logic [1:0] {
    IDLE, PACK, WRITE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [31:0]       lane_q, lane_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              accept;

  assign accept = (state_q == PACK) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      lane_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = PACK;
      PACK: begin
        if (accept && (idx_q == 2'd3 || in_last))
          state_d = WRITE;
      end
      WRITE: state_d = last_q ? DONE : PACK;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    hold_d = hold_q;
    lane_d = lane_q;
    mask_d = mask_q;
    idx_d  = idx_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          lane_d = '0;
          mask_d = '0;
          idx_d  = '0;
          last_d = 1'b0;
          cnt_d  = '0;
          wrap_d = 1'b0;
        end
      end
      PACK: begin
        if (accept) begin
          lane_d[{idx_q, 3'b000} +: 8] = in_data;
          mask_d[idx_q] = 1'b1;
          last_d = in_last;
          // Index stays put on the word-closing byte; WRITE clears it.
          if (idx_q != 2'd3 && !in_last)
            idx_d = idx_q + 2'd1;
        end
      end
      WRITE: begin
        // Keep the written address visible after the strobe.
        hold_d = addr_q;
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) wrap_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        lane_d = '0;
        mask_d = '0;
        idx_d  = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    writedata  = '0;
    address    = hold_q;
    busy       = 1'b0;
    done       = 1'b0;
    clken      = 1'b1;
    word_count = cnt_q;
    wrapped    = wrap_q;
    unique case (state_q)
      PACK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        chipselect = 1'b1;
        write      = 1'b1;
        byteenable = mask_q;
        writedata  = lane_q;
        address    = addr_q;
        busy       = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_onchip_mem_byte_loader.sv
// Self-checking bench for onchip_mem_byte_loader.
// Vector table of loads plus hand sequences; RAM writes go via a scoreboard.
module tb_onchip_mem_byte_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        busy;
  logic        done;
  logic [10:0] word_count;
  logic        wrapped;

  onchip_mem_byte_loader #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .address(address),
    .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata),
    .clken(clken), .busy(busy), .done(done),
    .word_count(word_count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [9:0]  base;
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          gaps;
    logic [10:0] exp_wc;
    logic        exp_wrap;
    logic [3:0]  exp_be_last;
  } vec_t;

  wr_t  sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  logic [3:0] last_be = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && write) begin
      wr_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write got=%0h want=none", address);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(address), 64'(e.a));
        chk("wr_data", 64'(writedata), 64'(e.d));
        chk("wr_be", 64'(byteenable), 64'(e.be));
        chk("wr_cs", 64'(chipselect), 64'd1);
        chk("wr_ready0", 64'(in_ready), 64'd0);
      end
      last_wr_cyc = cyc;
      last_be = byteenable;
    end
  end

  task automatic push_model(input logic [9:0] base, input int n,
                            input logic [7:0] first,
                            input logic [7:0] step);
    int nw;
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.a  = base + 10'(w);
      e.d  = '0;
      e.be = '0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = w * 4 + k;
        if (i < n) begin
          e.d[k*8 +: 8] = first + 8'(i) * step;
          e.be[k] = 1'b1;
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit acc;
    int n;
    in_data = b;
    in_valid = 1'b1;
    in_last = l;
    acc = 0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input logic [10:0] wc, input logic wr);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      else @(posedge clk);
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_lat", 64'(cyc - last_wr_cyc), 64'd1);
    chk("word_count", 64'(word_count), 64'(wc));
    chk("wrapped", 64'(wrapped), 64'(wr));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("wc_hold", 64'(word_count), 64'(wc));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    push_model(v.base, v.n, v.first, v.step);
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    pulse_start(v.base);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.first + 8'(i) * v.step, i == v.n - 1);
      if (v.gaps && i < v.n - 1) begin
        @(posedge clk);
        #1;
      end
    end
    wait_done(v.exp_wc, v.exp_wrap);
    chk("be_last", 64'(last_be), 64'(v.exp_be_last));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{10'h010, 8, 8'h11, 8'h11, 0, 11'd2, 1'b0, 4'hF};
    vecs[1] = '{10'h000, 3, 8'hAA, 8'h11, 0, 11'd1, 1'b0, 4'h7};
    vecs[2] = '{10'h3FF, 8, 8'h01, 8'h01, 0, 11'd2, 1'b1, 4'hF};
    vecs[3] = '{10'h123, 4, 8'h5A, 8'h03, 1, 11'd1, 1'b0, 4'hF};
    vecs[4] = '{10'h200, 5, 8'hF0, 8'h01, 1, 11'd2, 1'b0, 4'h1};
    vecs[5] = '{10'h3FE, 10, 8'h80, 8'h07, 0, 11'd3, 1'b1, 4'h3};

    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    in_data = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_be", 64'(byteenable), 64'd0);
    chk("rst_cs", 64'(chipselect), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_wd", 64'(writedata), 64'd0);
    chk("rst_clken", 64'(clken), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rst_wrap", 64'(wrapped), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start with a byte already valid: the byte must wait for PACK
    push_model(10'h020, 3, 8'hAA, 8'h11);
    in_data = 8'hAA;
    in_valid = 1'b1;
    start = 1'b1;
    base_addr = 10'h020;
    @(negedge clk);
    chk("start_vld_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_done(11'd1, 1'b0);

    // start pulses during PACK are ignored
    push_model(10'h100, 8, 8'h10, 8'h01);
    pulse_start(10'h100);
    send_byte(8'h10, 1'b0);
    send_byte(8'h11, 1'b0);
    pulse_start(10'h200);
    @(negedge clk);
    chk("ign_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 2; i < 6; i++) send_byte(8'h10 + 8'(i), 1'b0);
    pulse_start(10'h200);
    @(negedge clk);
    chk("ign_wc", 64'(word_count), 64'd1);
    @(posedge clk);
    #1;
    send_byte(8'h16, 1'b0);
    send_byte(8'h17, 1'b1);
    wait_done(11'd2, 1'b0);

    // reset in the middle of the second word
    push_model(10'h050, 4, 8'h30, 8'h01);
    pulse_start(10'h050);
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_write", 64'(write), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_wc", 64'(word_count), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd0);
    chk("mid_sb", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_nodone", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
